// File: rtl/lake_sched_port_ctrl.sv
// Static-schedule port controller: N-dimensional affine iterator that strobes `step` when the cycle counter hits each point's scheduled time.
// Optional feature macro: LAKE_SCHED_AUTO_RESTART_EN (restart the schedule instead of parking in DONE).
module lake_sched_port_ctrl #(
    parameter int NUM_DIMS = 6,
    parameter int EXTENT_W = 11,
    parameter int ADDR_W   = 9,
    parameter int SCHED_W  = 16,
    parameter int CFG_W    = 1 + 3 + ADDR_W + SCHED_W + NUM_DIMS*(EXTENT_W+ADDR_W+SCHED_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               stall,
    input  logic [CFG_W-1:0]   config_sched,
    output logic               step,
    output logic [ADDR_W-1:0]  addr,
    output logic               done,
    output logic               sched_err,
    output logic [SCHED_W-1:0] cycle_count
);

    localparam int HDR_W = 4 + ADDR_W + SCHED_W;
    localparam int DIM_W = EXTENT_W + ADDR_W + SCHED_W;

`ifdef LAKE_SCHED_AUTO_RESTART_EN
    localparam bit AUTO_RESTART = 1'b1;
`else
    localparam bit AUTO_RESTART = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_reg, state_next;
    logic [SCHED_W-1:0]  count_reg, count_next, count_inc;
    logic                err_reg, err_next;
    logic                pend_reg, pend_next;

    logic                enable;
    logic [2:0]          dim_m1_raw, dim_m1;
    logic [ADDR_W-1:0]   addr_start, addr_sum;
    logic [SCHED_W-1:0]  sched_start, sched_time;

    logic [NUM_DIMS-1:0] active, at_max, lam, inc;
    logic                last;
    logic                adv, clear_all;

    logic [ADDR_W-1:0]   apart [NUM_DIMS];
    logic [SCHED_W-1:0]  spart [NUM_DIMS];

    assign enable      = config_sched[0];
    assign dim_m1_raw  = config_sched[3:1];
    assign addr_start  = config_sched[4 +: ADDR_W];
    assign sched_start = config_sched[4+ADDR_W +: SCHED_W];
    assign dim_m1      = (int'(dim_m1_raw) >= NUM_DIMS) ? 3'(NUM_DIMS-1) : dim_m1_raw;

    // Each dimension keeps i_d and its running contributions i_d*stride_d as accumulators.
    generate
        for (genvar gi = 0; gi < NUM_DIMS; gi++) begin : g_dim
            logic [EXTENT_W-1:0] ext, iter_reg, iter_next;
            logic [ADDR_W-1:0]   astr, apart_reg, apart_next;
            logic [SCHED_W-1:0]  sstr, spart_reg, spart_next;

            assign ext  = config_sched[HDR_W + gi*DIM_W +: EXTENT_W];
            assign astr = config_sched[HDR_W + gi*DIM_W + EXTENT_W +: ADDR_W];
            assign sstr = config_sched[HDR_W + gi*DIM_W + EXTENT_W + ADDR_W +: SCHED_W];

            assign active[gi] = (gi <= int'(dim_m1));
            assign at_max[gi] = (iter_reg >= ext);
            assign inc[gi]    = active[gi] && lam[gi] && !at_max[gi];
            assign apart[gi]  = apart_reg;
            assign spart[gi]  = spart_reg;

            always_comb begin
                iter_next  = iter_reg;
                apart_next = apart_reg;
                spart_next = spart_reg;
                if (clear_all) begin
                    iter_next  = '0;
                    apart_next = '0;
                    spart_next = '0;
                end else if (adv && !last) begin
                    if (inc[gi]) begin
                        iter_next  = iter_reg + 1'b1;
                        apart_next = apart_reg + astr;
                        spart_next = spart_reg + sstr;
                    end else if (active[gi] && lam[gi] && at_max[gi]) begin
                        // inner dimension wraps because an outer one carries
                        iter_next  = '0;
                        apart_next = '0;
                        spart_next = '0;
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    iter_reg  <= '0;
                    apart_reg <= '0;
                    spart_reg <= '0;
                end else begin
                    iter_reg  <= iter_next;
                    apart_reg <= apart_next;
                    spart_reg <= spart_next;
                end
            end
        end
    endgenerate

    // lam[d]: every active dimension below d sits at its extent.
    always_comb begin
        last = 1'b1;
        lam  = '0;
        for (int d = 0; d < NUM_DIMS; d++) begin
            lam[d] = last;
            last   = last && (!active[d] || at_max[d]);
        end
    end

    always_comb begin
        addr_sum   = addr_start;
        sched_time = sched_start;
        for (int d = 0; d < NUM_DIMS; d++) begin
            if (active[d]) begin
                addr_sum   = addr_sum + apart[d];
                sched_time = sched_time + spart[d];
            end
        end
    end

    assign count_inc = (count_reg == '1) ? count_reg : count_reg + 1'b1;

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        err_next   = err_reg;
        pend_next  = pend_reg;
        adv        = 1'b0;
        clear_all  = 1'b0;
        step       = 1'b0;
        if (flush) begin
            state_next = IDLE;
            count_next = '0;
            err_next   = 1'b0;
            pend_next  = 1'b0;
            clear_all  = 1'b1;
        end else if (!stall) begin
            unique case (state_reg)
                IDLE: begin
                    if (enable) state_next = RUN;
                end
                RUN: begin
                    count_next = count_inc;
                    if (pend_reg) begin
                        count_next = '0;
                        pend_next  = 1'b0;
                    end else if (count_reg == sched_time) begin
                        step = 1'b1;
                        adv  = 1'b1;
                    end else if (count_reg > sched_time) begin
                        // missed slot: flag it and skip the point without a strobe
                        err_next = 1'b1;
                        adv      = 1'b1;
                    end
                    if (adv && last) begin
                        if (AUTO_RESTART) begin
                            clear_all = 1'b1;
                            pend_next = 1'b1;
                        end else begin
                            state_next = DONE;
                        end
                    end
                end
                DONE: begin
                    count_next = count_inc;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            count_reg <= '0;
            err_reg   <= 1'b0;
            pend_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            err_reg   <= err_next;
            pend_reg  <= pend_next;
        end
    end

    assign addr        = (state_reg == IDLE) ? '0 : addr_sum;
    assign done        = (state_reg == DONE) || pend_reg;
    assign sched_err   = err_reg;
    assign cycle_count = count_reg;

endmodule
